// File: rtl/exception_pc_ctrl_pkg.sv
// Shared encodings for the exception PC controller: FSM states, cause codes,
// PC-source mux codes and the cause priority helper.
package exception_pc_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_EXC_SAVE  = 2'd1,
        ST_EXC_FETCH = 2'd2,
        ST_EXC_LOAD  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OPCODE = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } cause_t;

    localparam logic [2:0] PC_A      = 3'b000;
    localparam logic [2:0] PC_ULAOUT = 3'b001;
    localparam logic [2:0] PC_SLAC   = 3'b010;
    localparam logic [2:0] PC_EPC    = 3'b011;
    localparam logic [2:0] PC_MDR    = 3'b100;
    localparam logic [2:0] PC_ULARES = 3'b101;
    localparam logic [2:0] PC_MEM    = 3'b110;
    localparam logic [2:0] PC_UNUSED = 3'b111;

    // Opcode beats overflow beats divide-by-zero when several flags coincide.
    function automatic cause_t pick_cause(input logic opcode, input logic ovf, input logic div0);
        cause_t c;
        c = CAUSE_NONE;
        if (opcode)
            c = CAUSE_OPCODE;
        else if (ovf)
            c = CAUSE_OVF;
        else if (div0)
            c = CAUSE_DIV0;
        return c;
    endfunction

endpackage

// File: rtl/exception_pc_ctrl_mem_wait_counter.sv
// Counts the memory-latency wait while the exception vector is being read;
// tc flags the last wait cycle.
module mem_wait_counter #(
    parameter int MEM_LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(MEM_LAT) + 1;
    localparam logic [W-1:0] LAST = W'(MEM_LAT - 1);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset)
            count_reg <= '0;
        else if (load)
            count_reg <= '0;
        else if (en)
            count_reg <= count_reg + W'(1);
    end

    assign tc = (count_reg == LAST);

endmodule

// File: rtl/exception_pc_ctrl.sv
// PC-source select and PC/EPC write control: passes main-control PC requests
// through in IDLE and runs the save-EPC / fetch-vector / load-PC exception sequence.
module exception_pc_ctrl
    import exception_pc_ctrl_pkg::*;
#(
    parameter int         MEM_LAT    = 2,
    parameter logic [7:0] VEC_OPCODE = 8'd253,
    parameter logic [7:0] VEC_OVF    = 8'd254,
    parameter logic [7:0] VEC_DIV0   = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pc_req_valid,
    input  logic [2:0] pc_req_src,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] PCmux,
    output logic       PCWrite,
    output logic       EPCWrite,
    output logic       ula_pc_m4,
    output logic       mem_rd,
    output logic [7:0] mem_vec_addr,
    output logic [1:0] exc_cause,
    output logic       stall
);

    state_t     state_reg;
    cause_t     cause_reg;
    logic [7:0] vec_reg;

    cause_t     cause_next;
    logic [7:0] vec_next;
    logic       any_exc;
    logic       wait_load;
    logic       wait_en;
    logic       wait_tc;

    assign any_exc    = exc_opcode | exc_ovf | exc_div0;
    assign cause_next = pick_cause(exc_opcode, exc_ovf, exc_div0);

    always_comb begin
        vec_next = VEC_DIV0;
        case (cause_next)
            CAUSE_OPCODE: vec_next = VEC_OPCODE;
            CAUSE_OVF:    vec_next = VEC_OVF;
            default:      vec_next = VEC_DIV0;
        endcase
    end

    // Counter is cleared while EPC is saved so the fetch window always starts at zero.
    assign wait_load = (state_reg == ST_EXC_SAVE);
    assign wait_en   = (state_reg == ST_EXC_FETCH);

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT)
    ) u_mem_wait_counter (
        .clk   (clk),
        .reset (reset),
        .load  (wait_load),
        .en    (wait_en),
        .tc    (wait_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cause_reg <= CAUSE_NONE;
            vec_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (any_exc) begin
                        cause_reg <= cause_next;
                        vec_reg   <= vec_next;
                        state_reg <= ST_EXC_SAVE;
                    end
                end
                ST_EXC_SAVE:  state_reg <= ST_EXC_FETCH;
                ST_EXC_FETCH: if (wait_tc) state_reg <= ST_EXC_LOAD;
                ST_EXC_LOAD:  state_reg <= ST_IDLE;
                default:      state_reg <= ST_IDLE;
            endcase
        end
    end

    // IDLE forwards the request combinationally; other states decode from state only.
    always_comb begin
        PCmux        = PC_A;
        PCWrite      = 1'b0;
        EPCWrite     = 1'b0;
        ula_pc_m4    = 1'b0;
        mem_rd       = 1'b0;
        mem_vec_addr = '0;
        stall        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (any_exc) begin
                    stall = 1'b1;
                end else begin
                    PCmux   = pc_req_src;
                    PCWrite = pc_req_valid && (pc_req_src != PC_UNUSED);
                end
            end
            ST_EXC_SAVE: begin
                ula_pc_m4 = 1'b1;
                EPCWrite  = 1'b1;
                stall     = 1'b1;
            end
            ST_EXC_FETCH: begin
                mem_rd       = 1'b1;
                mem_vec_addr = vec_reg;
                stall        = 1'b1;
            end
            ST_EXC_LOAD: begin
                PCmux   = PC_MEM;
                PCWrite = 1'b1;
                stall   = 1'b1;
            end
            default: ;
        endcase
    end

    assign exc_cause = cause_reg;

endmodule
